// File: rtl/alu_stream_engine.sv
// ---------------------------------------------------------------------------
// alu_stream_engine
//   Pulls a 3-beat command packet (operand A, operand B, opcode) from a
//   valid/ready input stream and executes one ALU operation on it. The
//   registered result and its flags go out on a valid/ready output stream.
//   Only one packet is in flight at a time. The engine does not accept input
//   while it is presenting a result.
//
// Parameters
//   DATA_WIDTH   width of beats, operands and result (power of 2, >= 4)
//   COUNT_WIDTH  width of the delivered-result counter
//
// Ports
//   clk_i           rising-edge clock
//   arst_n          asynchronous active-low reset
//   data_in         input beat: A, then B, then opcode (bits [2:0])
//   data_in_valid   input beat valid
//   data_in_ready   engine can take a beat (decoded from state)
//   data_out        registered ALU result
//   carry_out       carry (ADD) / borrow (SUB), else 0
//   zero_out        data_out == 0
//   data_out_valid  result valid (decoded from state)
//   data_out_ready  downstream accepts the result
//   pkt_count       number of results delivered, wraps
// ---------------------------------------------------------------------------
module alu_stream_engine #(
    parameter int DATA_WIDTH  = 8,
    parameter int COUNT_WIDTH = 8
) (
    input  logic                   clk_i,
    input  logic                   arst_n,
    input  logic [DATA_WIDTH-1:0]  data_in,
    input  logic                   data_in_valid,
    output logic                   data_in_ready,
    output logic [DATA_WIDTH-1:0]  data_out,
    output logic                   carry_out,
    output logic                   zero_out,
    output logic                   data_out_valid,
    input  logic                   data_out_ready,
    output logic [COUNT_WIDTH-1:0] pkt_count
);

    localparam int SHW = $clog2(DATA_WIDTH);

    typedef enum logic [1:0] {S_A, S_B, S_OP, S_OUT} state_t;

    typedef struct packed {
        logic [DATA_WIDTH-1:0] res;
        logic                  carry;
    } alu_rslt_t;

    state_t                state;
    logic [DATA_WIDTH-1:0] op_a;
    logic [DATA_WIDTH-1:0] op_b;
    alu_rslt_t             alu;

    logic in_hs;
    logic out_hs;

    // Both ready/valid depend on state only, so nothing from data_out_ready
    // reaches data_in_ready within a cycle.
    assign data_in_ready  = (state != S_OUT);
    assign data_out_valid = (state == S_OUT);

    assign in_hs  = data_in_valid  & data_in_ready;
    assign out_hs = data_out_valid & data_out_ready;

    // The ALU reads the opcode straight off the bus. The result is only
    // captured on the S_OP handshake, so there is no opcode register.
    always_comb begin
        alu = '0;
        unique case (data_in[2:0])
            3'd0: {alu.carry, alu.res} = {1'b0, op_a} + {1'b0, op_b};
            3'd1: begin
                alu.res   = op_a - op_b;
                alu.carry = (op_a < op_b);
            end
            3'd2: alu.res = op_a & op_b;
            3'd3: alu.res = op_a | op_b;
            3'd4: alu.res = op_a ^ op_b;
            3'd5: alu.res = op_a << op_b[SHW-1:0];
            3'd6: alu.res = op_a >> op_b[SHW-1:0];
            3'd7: alu.res = op_a;
        endcase
    end

    always_ff @(posedge clk_i or negedge arst_n) begin
        if (!arst_n) begin
            state     <= S_A;
            op_a      <= '0;
            op_b      <= '0;
            data_out  <= '0;
            carry_out <= 1'b0;
            zero_out  <= 1'b0;
            pkt_count <= '0;
        end else begin
            unique case (state)
                S_A: if (in_hs) begin
                    op_a  <= data_in;
                    state <= S_B;
                end
                S_B: if (in_hs) begin
                    op_b  <= data_in;
                    state <= S_OP;
                end
                S_OP: if (in_hs) begin
                    data_out  <= alu.res;
                    carry_out <= alu.carry;
                    zero_out  <= (alu.res == '0);
                    state     <= S_OUT;
                end
                S_OUT: if (out_hs) begin
                    pkt_count <= pkt_count + COUNT_WIDTH'(1);
                    state     <= S_A;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_stream_engine.sv
// ---------------------------------------------------------------------------
// tb_alu_stream_engine
//   Directed bench for alu_stream_engine with DATA_WIDTH=8 and COUNT_WIDTH=8.
//   The driver pushes a hand-computed expected result into a scoreboard queue
//   when it issues each opcode beat. A separate monitor pops one entry and
//   compares it on every output handshake. Inputs change 1 time unit after
//   the rising edge. All sampling happens on the falling edge.
// ---------------------------------------------------------------------------
module tb_alu_stream_engine;

    logic       clk_i = 1'b0;
    logic       arst_n = 1'b0;
    logic [7:0] data_in = '0;
    logic       data_in_valid = 1'b0;
    logic       data_in_ready;
    logic [7:0] data_out;
    logic       carry_out;
    logic       zero_out;
    logic       data_out_valid;
    logic       data_out_ready = 1'b1;
    logic [7:0] pkt_count;

    typedef struct packed {
        logic [7:0] d;
        logic       c;
        logic       z;
    } exp_t;

    exp_t       sb[$];
    logic [7:0] exp_cnt = '0;
    int         n_chk  = 0;
    int         n_fail = 0;

    alu_stream_engine #(.DATA_WIDTH(8), .COUNT_WIDTH(8)) dut (
        .clk_i          (clk_i),
        .arst_n         (arst_n),
        .data_in        (data_in),
        .data_in_valid  (data_in_valid),
        .data_in_ready  (data_in_ready),
        .data_out       (data_out),
        .carry_out      (carry_out),
        .zero_out       (zero_out),
        .data_out_valid (data_out_valid),
        .data_out_ready (data_out_ready),
        .pkt_count      (pkt_count)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Called 1 time unit after a rising edge. It returns 1 time unit after
    // the edge on which the beat was accepted.
    task automatic send_beat(input logic [7:0] v, input int gap);
        int t;
        for (int i = 0; i < gap; i++) begin
            @(posedge clk_i); #1;
        end
        data_in       = v;
        data_in_valid = 1'b1;
        t = 0;
        forever begin
            @(negedge clk_i);
            if (data_in_ready) break;
            t++;
            if (t > 50) begin
                chk("in_ready_timeout", 32'(data_in_ready), 32'd1);
                break;
            end
        end
        @(posedge clk_i); #1;
        data_in_valid = 1'b0;
    endtask

    task automatic send_pkt(input logic [7:0] a, input logic [7:0] b, input logic [7:0] op,
                            input logic [7:0] er, input logic ec, input logic ez, input int gap);
        exp_t e;
        send_beat(a, gap);
        send_beat(b, gap);
        e.d = er; e.c = ec; e.z = ez;
        sb.push_back(e);
        send_beat(op, gap);
        // Latency 1: the result must be valid in the cycle after the opcode beat.
        @(negedge clk_i);
        chk("latency_valid", 32'(data_out_valid), 32'd1);
        @(posedge clk_i); #1;
    endtask

    task automatic do_reset();
        arst_n = 1'b0;
        @(negedge clk_i);
        @(posedge clk_i); #1;
        arst_n = 1'b1;
    endtask

    // Monitor: every output handshake is checked against the scoreboard head.
    // The counter value seen before the increment is checked at the same time.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk_i);
            if (!arst_n) begin
                exp_cnt = '0;
            end else if (data_out_valid && data_out_ready) begin
                if (sb.size() == 0) begin
                    chk("unexpected_output", 32'(data_out), 32'hFFFF_FFFF);
                end else begin
                    e = sb.pop_front();
                    chk("data_out",  32'(data_out),  32'(e.d));
                    chk("carry_out", 32'(carry_out), 32'(e.c));
                    chk("zero_out",  32'(zero_out),  32'(e.z));
                    chk("pkt_count", 32'(pkt_count), 32'(exp_cnt));
                end
                exp_cnt = exp_cnt + 8'd1;
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] a;
        // Reset state.
        do_reset();
        @(negedge clk_i);
        chk("rst_in_ready",  32'(data_in_ready),  32'd1);
        chk("rst_out_valid", 32'(data_out_valid), 32'd0);
        chk("rst_data_out",  32'(data_out),       32'd0);
        chk("rst_carry",     32'(carry_out),      32'd0);
        chk("rst_zero",      32'(zero_out),       32'd0);
        chk("rst_pkt_count", 32'(pkt_count),      32'd0);
        @(posedge clk_i); #1;

        // ADD with carry, then the counter after the first delivery.
        send_pkt(8'hF0, 8'h20, 8'h00, 8'h10, 1'b1, 1'b0, 0);
        @(negedge clk_i);
        chk("pkt_count_after_first", 32'(pkt_count), 32'd1);
        @(posedge clk_i); #1;

        // SUB equal, SUB borrow, SHL using only the low 3 bits of B, other ops.
        send_pkt(8'h05, 8'h05, 8'h01, 8'h00, 1'b0, 1'b1, 0);
        send_pkt(8'h03, 8'h05, 8'h01, 8'hFE, 1'b1, 1'b0, 0);
        send_pkt(8'h81, 8'h09, 8'h05, 8'h02, 1'b0, 1'b0, 0);
        send_pkt(8'hFF, 8'h01, 8'h00, 8'h00, 1'b1, 1'b1, 1);
        send_pkt(8'hF0, 8'h3C, 8'h02, 8'h30, 1'b0, 1'b0, 0);
        send_pkt(8'h0F, 8'h30, 8'hF3, 8'h3F, 1'b0, 1'b0, 2);
        send_pkt(8'hAA, 8'hAA, 8'h04, 8'h00, 1'b0, 1'b1, 0);
        send_pkt(8'h80, 8'h0B, 8'h06, 8'h10, 1'b0, 1'b0, 0);

        // Backpressure: the result must hold steady and input must stay blocked.
        data_out_ready = 1'b0;
        send_pkt(8'h01, 8'h02, 8'h00, 8'h03, 1'b0, 1'b0, 0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk_i);
            chk("bp_data_out",  32'(data_out),       32'h03);
            chk("bp_out_valid", 32'(data_out_valid), 32'd1);
            chk("bp_in_ready",  32'(data_in_ready),  32'd0);
        end
        @(posedge clk_i); #1;
        data_out_ready = 1'b1;
        @(posedge clk_i); #1;
        @(negedge clk_i);
        chk("bp_release_in_ready",  32'(data_in_ready),  32'd1);
        chk("bp_release_out_valid", 32'(data_out_valid), 32'd0);
        @(posedge clk_i); #1;

        // Gapped PASS traffic from a clean counter: 256 deliveries wrap to 0.
        do_reset();
        for (int i = 0; i < 256; i++) begin
            a = 8'(i);
            send_pkt(a, 8'($urandom), {5'($urandom), 3'd7}, a, 1'b0, (a == 8'h00),
                     int'($urandom_range(0, 3)));
        end
        @(negedge clk_i);
        chk("wrap_pkt_count", 32'(pkt_count), 32'd0);
        @(posedge clk_i); #1;

        // Reset mid-packet: the partial packet is dropped and 0x05 becomes A.
        send_beat(8'h11, 0);
        send_beat(8'h22, 0);
        arst_n = 1'b0;
        @(negedge clk_i);
        chk("midrst_in_ready", 32'(data_in_ready), 32'd1);
        @(posedge clk_i); #1;
        arst_n = 1'b1;
        send_pkt(8'h05, 8'h03, 8'h00, 8'h08, 1'b0, 1'b0, 0);

        repeat (3) @(posedge clk_i);
        @(negedge clk_i);
        chk("scoreboard_drained", 32'(sb.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
